ga23_rom_arbiter: RTL and testbench
===================================

// Module: ga23_rom_arbiter
// PURPOSE
// - Responder for the three GA23 layer tile-ROM request ports (toggle handshake, 22-bit word addr, 32-bit data).
// - Round-robin arbitrates them onto one 64-bit SDRAM request channel.
// - Keeps a one-line (64-bit) cache per port, so sequential 32-bit fetches from the same line skip SDRAM.
// - Sits between the three ga23_layer instances and the SDRAM controller, replacing the direct sdram hookup.
// PARAMETERS
// - ROM_BASE   25'h0  byte offset of tile ROM in SDRAM, added to every sdr_addr
// - CACHE_EN   1      1: per-port line cache active; 0: every request goes to SDRAM
// PORTS
// - clk          in   1   system clock; single clock domain
// - reset_n      in   1   asynchronous, active-low reset
// - addr_a/b/c   in   22  32-bit-word address per port; stable while that port is pending
// - req_a/b/c    in   1   request toggle; pending when req_x != rdy_x
// - data_a/b/c   out  32  returned word; valid once rdy_x == req_x
// - rdy_a/b/c    out  1   completion toggle; set equal to req_x when data_x is updated
// - flush        in   1   level; invalidates all cache lines (ROM download / bank change)
// - sdr_addr     out  25  byte address of 64-bit line = ROM_BASE + {addr[21:1],3'b000}, mod 2^25
// - sdr_req      out  1   SDRAM request toggle
// - sdr_rdy      in   1   SDRAM completion toggle; sdr_data valid when sdr_rdy == sdr_req
// - sdr_data     in   64  line data; word 0 in [31:0], word 1 in [63:32]
// BEHAVIOUR
// - Reset (async, reset_n=0): all rdy_x=0, data_x=0, sdr_req=0, sdr_addr=0, cache valid=0, last_grant=2, state=IDLE.
// - pending_x = req_x ^ rdy_x. Requesters never toggle req_x while pending_x=1.
// - FSM has two states: IDLE, WAIT.
// - IDLE, arbitration:
//   - grant g = first pending port scanning (last_grant+1)%3, then +2, then +3.
//   - Hit when CACHE_EN && valid[g] && tag[g]==addr_g[21:1].
// - IDLE, hit: next edge data_g <= line[g] word addr_g[0]; rdy_g <= req_g; last_grant <= g; stay IDLE.
// - IDLE, miss:
//   - next edge sdr_addr <= line address; sdr_req <= ~sdr_req.
//   - Latch g, addr_g and nocache <= flush; go WAIT.
// - WAIT:
//   - On sdr_rdy == sdr_req: data_g <= selected word; rdy_g <= req_g; last_grant <= g; go IDLE.
//   - Same edge: if !nocache && !flush, line[g] <= sdr_data, tag[g] <= addr[21:1], valid[g] <= 1.
//   - A flush asserted during WAIT sets nocache.
// - Latency:
//   - Hit: rdy toggles 1 clk after the req toggle is visible.
//   - Miss: rdy toggles 1 clk after the SDRAM completion, plus the 1 clk issue cycle.
// - Throughput: one grant per clk on hits; at most one SDRAM transaction outstanding.
// - Simultaneous pending: strict round-robin, no port waits more than 2 grants.
// - Hits are arbitrated like misses (no bypass).
// - Flush during a hit cycle: the hit still completes with old data; valid clears the same edge.
// - flush held high: every request misses; SDRAM data is still delivered.
// - Address wrap: ROM_BASE + offset truncated to 25 bits, no error.
// - Reset mid-WAIT: transaction abandoned; the SDRAM side is reset by the same reset_n, so toggles realign at 0.
// - CACHE_EN=0: valid never sets; behaviour is otherwise identical.
// STRUCTURE
// - ga23_pkg holds:
//   - localparam GA23_ROM_PORTS = 3
//   - typedef logic [1:0] ga23_port_t
//   - typedef enum {ARB_IDLE, ARB_WAIT} ga23_arb_state_t
//   - typedef logic [21:0] ga23_rom_addr_t
// - Sub-module ga23_line_cache: per-port tag/valid/64-bit line, with hit compare and word select.
// - Arbiter FSM and toggle registers stay in this module.
// TESTING
// - Reset, then one req_a toggle at addr 22'h000010:
//   - sdr_req toggles, sdr_addr = ROM_BASE+25'h40.
//   - Return 64'hDDDDCCCC_BBBBAAAA: data_a = 32'hBBBBAAAA, rdy_a = req_a.
// - Then req_a at 22'h000011: no sdr_req toggle; 1 clk later data_a = 32'hDDDDCCCC.
// - All three ports pending on different lines, last_grant=2:
//   - SDRAM issue order is a, b, c.
//   - Each rdy toggles only after its own completion.
// - flush pulsed during WAIT for port b:
//   - data_b is delivered.
//   - A repeat request to the same line misses and re-issues sdr_req.
// - reset_n low while in WAIT: all outputs 0 asynchronously; after release, a new req_c is serviced normally.
// - CACHE_EN=0 with back-to-back same-line requests on port a: every request toggles sdr_req.

Source files
------------

// File: rtl/ga23_pkg.sv
// Shared types and helpers for the GA23 tile-ROM arbiter and its line cache.
package ga23_pkg;

  localparam int GA23_ROM_PORTS = 3;

  typedef logic [1:0]  ga23_port_t;
  typedef logic [21:0] ga23_rom_addr_t;
  typedef enum logic {ARB_IDLE, ARB_WAIT} ga23_arb_state_t;

  // Port index `step` places after `last`, modulo the port count (step is 1..3).
  function automatic ga23_port_t ga23_rr_next(input ga23_port_t last, input logic [1:0] step);
    logic [2:0] s;
    s = {1'b0, last} + {1'b0, step};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [31:0] ga23_word_sel(input logic [63:0] line, input logic odd);
    return odd ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/ga23_rom_arbiter_if.sv
// Bundle of the three tile-ROM request ports, the flush level and the SDRAM request channel.
interface ga23_rom_arbiter_if;
  import ga23_pkg::*;

  ga23_rom_addr_t addr_a, addr_b, addr_c;
  logic           req_a, req_b, req_c;
  logic [31:0]    data_a, data_b, data_c;
  logic           rdy_a, rdy_b, rdy_c;
  logic           flush;
  logic [24:0]    sdr_addr;
  logic           sdr_req;
  logic           sdr_rdy;
  logic [63:0]    sdr_data;

  modport slave (
    input  addr_a, addr_b, addr_c, req_a, req_b, req_c, flush, sdr_rdy, sdr_data,
    output data_a, data_b, data_c, rdy_a, rdy_b, rdy_c, sdr_addr, sdr_req
  );

  modport master (
    output addr_a, addr_b, addr_c, req_a, req_b, req_c, flush, sdr_rdy, sdr_data,
    input  data_a, data_b, data_c, rdy_a, rdy_b, rdy_c, sdr_addr, sdr_req
  );
endinterface

// File: rtl/ga23_line_cache.sv
// One 64-bit line per request port: tag/valid storage, hit compare and word select.
module ga23_line_cache
  import ga23_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           i_flush,
  input  ga23_port_t     i_lk_port,
  input  ga23_rom_addr_t i_lk_addr,
  output logic           o_hit,
  output logic [31:0]    o_word,
  input  logic           i_fill,
  input  ga23_port_t     i_fill_port,
  input  ga23_rom_addr_t i_fill_addr,
  input  logic [63:0]    i_fill_line
);

  logic [GA23_ROM_PORTS-1:0] r_valid;
  logic [20:0]               r_tag  [GA23_ROM_PORTS];
  logic [63:0]               r_line [GA23_ROM_PORTS];

  // Flush wins over a fill on the same edge, so a line fetched across a flush is never kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_fill && (CACHE_EN != 1'b0)) begin
      r_valid[i_fill_port] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_fill) begin
      r_tag[i_fill_port]  <= i_fill_addr[21:1];
      r_line[i_fill_port] <= i_fill_line;
    end
  end

  assign o_hit  = (CACHE_EN != 1'b0) && r_valid[i_lk_port] &&
                  (r_tag[i_lk_port] == i_lk_addr[21:1]);
  assign o_word = ga23_word_sel(r_line[i_lk_port], i_lk_addr[0]);

endmodule

// File: rtl/ga23_rom_arbiter.sv
// Round-robin arbiter of three toggle-handshake tile-ROM ports onto one 64-bit SDRAM channel.
module ga23_rom_arbiter
  import ga23_pkg::*;
#(
  parameter logic [24:0] ROM_BASE = 25'h0,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  ga23_rom_arbiter_if.slave  bus
);

  ga23_rom_addr_t            w_addr [GA23_ROM_PORTS];
  logic [GA23_ROM_PORTS-1:0] w_req;
  logic [GA23_ROM_PORTS-1:0] w_pend;
  ga23_port_t                w_gnt;
  logic                      w_any;
  logic                      w_hit;
  logic [31:0]               w_hit_word;
  logic                      w_done;
  logic                      w_fill;

  ga23_arb_state_t           r_state;
  ga23_port_t                r_last;
  ga23_port_t                r_gnt;
  ga23_rom_addr_t            r_addr;
  logic                      r_nocache;
  logic                      r_sdr_req;
  logic [24:0]               r_sdr_addr;
  logic [31:0]               r_data [GA23_ROM_PORTS];
  logic [GA23_ROM_PORTS-1:0] r_rdy;

  assign w_addr[0] = bus.addr_a;
  assign w_addr[1] = bus.addr_b;
  assign w_addr[2] = bus.addr_c;
  assign w_req     = {bus.req_c, bus.req_b, bus.req_a};
  assign w_pend    = w_req ^ r_rdy;

  // Scan starts one past the last granted port so every pending port is served within two grants.
  always_comb begin
    w_any = 1'b0;
    w_gnt = r_last;
    for (int k = 1; k <= 3; k++) begin
      if (!w_any && w_pend[ga23_rr_next(r_last, 2'(k))]) begin
        w_gnt = ga23_rr_next(r_last, 2'(k));
        w_any = 1'b1;
      end
    end
  end

  assign w_done = (r_state == ARB_WAIT) && (bus.sdr_rdy == r_sdr_req);
  assign w_fill = w_done && !r_nocache && !bus.flush;

  ga23_line_cache #(.CACHE_EN(CACHE_EN)) u_cache (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_flush     (bus.flush),
    .i_lk_port   (w_gnt),
    .i_lk_addr   (w_addr[w_gnt]),
    .o_hit       (w_hit),
    .o_word      (w_hit_word),
    .i_fill      (w_fill),
    .i_fill_port (r_gnt),
    .i_fill_addr (r_addr),
    .i_fill_line (bus.sdr_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ARB_IDLE;
      r_last     <= 2'd2;
      r_gnt      <= 2'd0;
      r_addr     <= '0;
      r_nocache  <= 1'b0;
      r_sdr_req  <= 1'b0;
      r_sdr_addr <= '0;
      r_rdy      <= '0;
      for (int i = 0; i < GA23_ROM_PORTS; i++) r_data[i] <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            if (w_hit) begin
              r_data[w_gnt] <= w_hit_word;
              r_rdy[w_gnt]  <= w_req[w_gnt];
              r_last        <= w_gnt;
            end else begin
              r_sdr_addr <= ROM_BASE + {1'b0, w_addr[w_gnt][21:1], 3'b000};
              r_sdr_req  <= ~r_sdr_req;
              r_gnt      <= w_gnt;
              r_addr     <= w_addr[w_gnt];
              r_nocache  <= bus.flush;
              r_state    <= ARB_WAIT;
            end
          end
        end
        ARB_WAIT: begin
          if (bus.flush) r_nocache <= 1'b1;
          if (w_done) begin
            r_data[r_gnt] <= ga23_word_sel(bus.sdr_data, r_addr[0]);
            r_rdy[r_gnt]  <= w_req[r_gnt];
            r_last        <= r_gnt;
            r_state       <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.data_a   = r_data[0];
  assign bus.data_b   = r_data[1];
  assign bus.data_c   = r_data[2];
  assign bus.rdy_a    = r_rdy[0];
  assign bus.rdy_b    = r_rdy[1];
  assign bus.rdy_c    = r_rdy[2];
  assign bus.sdr_addr = r_sdr_addr;
  assign bus.sdr_req  = r_sdr_req;

endmodule

// File: tb/tb_ga23_rom_arbiter.sv
// Bench for ga23_rom_arbiter: SDRAM responder, per-port cache reference model, directed and random requests.
module tb_ga23_rom_arbiter;

  localparam logic [24:0] BASE = 25'h180_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ga23_rom_arbiter_if bus ();
  ga23_rom_arbiter_if bus2 ();

  ga23_rom_arbiter #(.ROM_BASE(BASE), .CACHE_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));
  ga23_rom_arbiter #(.ROM_BASE(25'h0), .CACHE_EN(1'b0)) dut_nc (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave));

  logic [21:0] t_addr [3];
  logic        t_req  [3];
  logic        t_flush;
  logic        sdr_rdy;
  logic [63:0] sdr_data;
  logic [31:0] w_data [3];
  logic        w_rdy  [3];

  assign bus.addr_a = t_addr[0];
  assign bus.addr_b = t_addr[1];
  assign bus.addr_c = t_addr[2];
  assign bus.req_a  = t_req[0];
  assign bus.req_b  = t_req[1];
  assign bus.req_c  = t_req[2];
  assign bus.flush  = t_flush;
  assign bus.sdr_rdy  = sdr_rdy;
  assign bus.sdr_data = sdr_data;
  assign w_data[0] = bus.data_a;
  assign w_data[1] = bus.data_b;
  assign w_data[2] = bus.data_c;
  assign w_rdy[0]  = bus.rdy_a;
  assign w_rdy[1]  = bus.rdy_b;
  assign w_rdy[2]  = bus.rdy_c;

  logic [21:0] n_addr;
  logic        n_req;
  logic        n_rdy_s;
  logic [63:0] n_sdata;
  assign bus2.addr_a = n_addr;
  assign bus2.addr_b = '0;
  assign bus2.addr_c = '0;
  assign bus2.req_a  = n_req;
  assign bus2.req_b  = 1'b0;
  assign bus2.req_c  = 1'b0;
  assign bus2.flush  = 1'b0;
  assign bus2.sdr_rdy  = n_rdy_s;
  assign bus2.sdr_data = n_sdata;

  int n_chk = 0;
  int n_fail = 0;
  int n_issue = 0;
  int n_done = 0;
  int n2_issue = 0;
  bit hold_sdr = 1'b0;
  bit rand_lat = 1'b0;
  logic [24:0] issue_q [$];
  logic [63:0] mem [logic [24:0]];
  bit          mvalid [3];
  logic [20:0] mtag [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_line(input logic [24:0] a);
    if (mem.exists(a)) return mem[a];
    return {7'h5A, a, 7'h3C, ~a};
  endfunction

  // Byte address of the 64-bit line holding 32-bit word a, wrapped to the 25-bit SDRAM space.
  function automatic logic [24:0] line_of(input logic [24:0] base, input logic [21:0] a);
    longint t;
    t = (longint'(base) + longint'(a / 2) * 8) % (longint'(1) << 25);
    return t[24:0];
  endfunction

  function automatic logic [31:0] word_of(input logic [63:0] line, input logic [21:0] a);
    return (a % 2 == 1) ? line[63:32] : line[31:0];
  endfunction

  // SDRAM stand-in for the cached instance: one transaction at a time, programmable delay.
  initial begin
    int lat;
    logic [24:0] a;
    sdr_rdy = 1'b0;
    sdr_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sdr_rdy = 1'b0;
      end else if (bus.sdr_req != sdr_rdy) begin
        a = bus.sdr_addr;
        issue_q.push_back(a);
        n_issue++;
        lat = rand_lat ? int'($urandom_range(0, 3)) : 1;
        while ((hold_sdr || lat > 0) && reset_n) begin
          @(negedge clk);
          if (!hold_sdr) lat--;
        end
        if (reset_n) begin
          sdr_data = mem_line(a);
          sdr_rdy = bus.sdr_req;
          n_done++;
        end else begin
          sdr_rdy = 1'b0;
        end
      end
    end
  end

  initial begin
    n_rdy_s = 1'b0;
    n_sdata = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        n_rdy_s = 1'b0;
      end else if (bus2.sdr_req != n_rdy_s) begin
        n2_issue++;
        n_sdata = mem_line(bus2.sdr_addr);
        n_rdy_s = bus2.sdr_req;
      end
    end
  end

  task automatic do_req(input int p, input logic [21:0] a);
    int n0, cyc;
    bit miss;
    logic [24:0] la;
    miss = !(mvalid[p] && mtag[p] == 21'(a / 2));
    la = line_of(BASE, a);
    n0 = n_issue;
    t_addr[p] = a;
    t_req[p] = ~t_req[p];
    cyc = 0;
    while (w_rdy[p] !== t_req[p] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("timeout_p%0d", p), 64'(cyc < 200), 64'd1);
    chk($sformatf("sdr_issue_p%0d", p), 64'(n_issue - n0), 64'(miss));
    if (miss && issue_q.size() > 0) chk($sformatf("sdr_addr_p%0d", p), 64'(issue_q[$]), 64'(la));
    if (!miss) chk($sformatf("hit_lat_p%0d", p), 64'(cyc), 64'd1);
    chk($sformatf("data_p%0d", p), 64'(w_data[p]), 64'(word_of(mem_line(la), a)));
    if (miss) begin
      mvalid[p] = !t_flush;
      mtag[p] = 21'(a / 2);
    end
  endtask

  task automatic clear_model();
    for (int p = 0; p < 3; p++) mvalid[p] = 1'b0;
  endtask

  initial begin
    int cyc;
    int order [$];
    int done_at [3];
    bit done [3];
    int n0;
    logic [21:0] a;

    for (int p = 0; p < 3; p++) begin
      t_addr[p] = '0;
      t_req[p] = 1'b0;
    end
    t_flush = 1'b0;
    n_addr = '0;
    n_req = 1'b0;
    clear_model();

    repeat (2) @(negedge clk);
    chk("rst_sdr_req", 64'(bus.sdr_req), 64'd0);
    chk("rst_sdr_addr", 64'(bus.sdr_addr), 64'd0);
    chk("rst_rdy", 64'({bus.rdy_a, bus.rdy_b, bus.rdy_c}), 64'd0);
    chk("rst_data", {bus.data_a ^ bus.data_b, bus.data_c}, 64'd0);
    chk("rst_nc", 64'({bus2.rdy_a, bus2.rdy_b, bus2.rdy_c, bus2.sdr_req, bus2.sdr_addr}), 64'd0);
    chk("rst_nc_data", 64'(bus2.data_a | bus2.data_b | bus2.data_c), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // All three ports pending at once straight out of reset: service order a, b, c.
    t_addr[0] = 22'h000100;
    t_addr[1] = 22'h000200;
    t_addr[2] = 22'h000301;
    for (int p = 0; p < 3; p++) begin
      done[p] = 1'b0;
      t_req[p] = ~t_req[p];
    end
    cyc = 0;
    while (!(done[0] && done[1] && done[2]) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 3; p++) begin
        if (!done[p] && w_rdy[p] === t_req[p]) begin
          done[p] = 1'b1;
          order.push_back(p);
          done_at[p] = n_done;
        end
      end
    end
    chk("rr_timeout", 64'(cyc < 300), 64'd1);
    chk("rr_count", 64'(order.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rr_order%0d", k), 64'(order.size() > k ? order[k] : 9), 64'(k));
      chk($sformatf("rr_issue%0d", k), 64'(issue_q.size() > k ? issue_q[k] : 25'h0),
          64'(line_of(BASE, t_addr[k])));
      chk($sformatf("rr_after_own%0d", k), 64'(done_at[k]), 64'(k + 1));
      chk($sformatf("rr_data%0d", k), 64'(w_data[k]),
          64'(word_of(mem_line(line_of(BASE, t_addr[k])), t_addr[k])));
      mvalid[k] = 1'b1;
      mtag[k] = 21'(t_addr[k] / 2);
    end

    mem[BASE + 25'h40] = 64'hDDDDCCCC_BBBBAAAA;
    do_req(0, 22'h000010);
    chk("t1_sdr_addr", 64'(issue_q[$]), 64'(BASE + 25'h40));
    chk("t1_data", 64'(w_data[0]), 64'h0000_0000_BBBB_AAAA);
    chk("t1_rdy", 64'(w_rdy[0]), 64'(t_req[0]));
    do_req(0, 22'h000011);
    chk("t2_data", 64'(w_data[0]), 64'h0000_0000_DDDD_CCCC);

    do_req(1, 22'h3FFFFF);
    chk("wrap_addr", 64'(issue_q[$]), 64'h07F_FFF8);

    // Flush pulse while port b's line is in flight.
    hold_sdr = 1'b1;
    fork
      do_req(1, 22'h001234);
      begin
        repeat (3) @(negedge clk);
        t_flush = 1'b1;
        @(negedge clk);
        t_flush = 1'b0;
        hold_sdr = 1'b0;
      end
    join
    clear_model();
    do_req(1, 22'h001234);

    t_flush = 1'b1;
    @(negedge clk);
    clear_model();
    do_req(2, 22'h000040);
    do_req(2, 22'h000041);
    t_flush = 1'b0;

    rand_lat = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        t_flush = 1'b1;
        @(negedge clk);
        t_flush = 1'b0;
        clear_model();
      end
      if ($urandom_range(0, 7) == 0) a = 22'($urandom);
      else a = 22'h000200 + 22'($urandom_range(0, 5));
      do_req(int'($urandom_range(0, 2)), a);
    end
    rand_lat = 1'b0;

    // Reset asserted between clock edges while port c waits on SDRAM.
    hold_sdr = 1'b1;
    t_addr[2] = 22'h000055;
    t_req[2] = ~t_req[2];
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_sdr_req", 64'(bus.sdr_req), 64'd0);
    chk("arst_sdr_addr", 64'(bus.sdr_addr), 64'd0);
    chk("arst_rdy", 64'({bus.rdy_a, bus.rdy_b, bus.rdy_c}), 64'd0);
    chk("arst_data", {bus.data_a | bus.data_b, bus.data_c}, 64'd0);
    for (int p = 0; p < 3; p++) t_req[p] = 1'b0;
    n_req = 1'b0;
    hold_sdr = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_model();
    issue_q.delete();
    @(negedge clk);
    do_req(2, 22'h000055);

    for (int i = 0; i < 4; i++) begin
      n0 = n2_issue;
      n_addr = 22'h000020 + 22'(i % 2);
      n_req = ~n_req;
      cyc = 0;
      while (bus2.rdy_a !== n_req && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("nc_timeout%0d", i), 64'(cyc < 100), 64'd1);
      chk($sformatf("nc_issue%0d", i), 64'(n2_issue - n0), 64'd1);
      chk($sformatf("nc_data%0d", i), 64'(bus2.data_a),
          64'(word_of(mem_line(line_of(25'h0, n_addr)), n_addr)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
